regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the single-width CPU register file.
- Sits between decode and write-back in the MIPS core.
- Decodes rs/rt/rd from the instruction word and provides two registered read ports and one write port.
- Adds rt/rd/link write-destination select, a hardwired zero register, write-completion pulses, and a sequenced bulk-clear engine.
- Optional same-cycle write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W. Legal range 3..5.
- ZERO_REG, 1, when 1 register 0 reads as 0 and writes to it are discarded.
- LINK_REG, 31, write address used when wr_dst_sel selects link (JAL/JALR); must be < DEPTH.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- valid  input  1  read request; sample rs/rt this cycle
- instruction  input  32  rs=[25:21], rt=[20:16], rd=[15:11]; low ADDR_W bits of each field used
- wr_en  input  1  write request
- wr_dst_sel  input  2  0=rt, 1=rd, 2=LINK_REG, 3=reserved (write dropped, no pulse)
- wr_data  input  DATA_W  write data
- clr_req  input  1  start bulk clear of all registers
- rd_data1  output  DATA_W  registered value of rs
- rd_data2  output  DATA_W  registered value of rt
- rd_valid  output  1  rd_data1/2 updated by previous-cycle read
- end_instr  output  1  one-cycle pulse: write accepted last cycle (PC fetch-next)
- busy  output  1  clear engine active

Behaviour:
Reset:
- reset low, asynchronously: all registers = 0, rd_data1/2 = 0, rd_valid = 0, end_instr = 0, busy = 0, state = IDLE, clear index = 0.
- reset asserted mid-clear aborts the clear immediately; registers are zeroed by the reset itself.

States: IDLE, CLEAR.

IDLE:
- Read: on a posedge with valid=1, rd_data1 <= reg[rs] and rd_data2 <= reg[rt]; rd_valid <= 1.
- No read: with valid=0, rd_valid <= 0 and rd_data1/2 hold their values.
- Read latency: 1 cycle.
- Zero register: with ZERO_REG=1, a read of address 0 returns 0 regardless of array contents.
- Write: on a posedge with wr_en=1 and wr_dst_sel in {0,1,2}, reg[addr] <= wr_data; end_instr <= 1 for exactly one cycle; otherwise end_instr <= 0.
- Write address: rt, rd, or LINK_REG according to wr_dst_sel.
- Write to address 0 with ZERO_REG=1: data discarded, end_instr still pulses.
- wr_dst_sel=3: no write, no pulse.
- Read and write to the same address in the same cycle (bypass disabled): the read returns the old value; the new value is visible from the next read.
- clr_req=1: go to CLEAR, index <= 0, busy <= 1.
- clr_req and wr_en in the same cycle: clear wins; the write is dropped and no end_instr.
- clr_req and valid in the same cycle: the read is still performed (rd_valid=1).

CLEAR:
- Each cycle: reg[index] <= 0, index <= index+1.
- After writing index DEPTH-1: state <= IDLE, busy <= 0.
- Total duration: exactly DEPTH cycles with busy=1.
- valid, wr_en and clr_req are ignored while in CLEAR; rd_valid = 0, end_instr = 0, rd_data held.
- Requesters must hold requests until busy=0.

Arithmetic: no sign handling; data is stored verbatim at DATA_W bits.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: in IDLE, when an accepted write (not dropped, not to zero reg with ZERO_REG=1) targets rs and/or rt in the same cycle as valid=1, the matching rd_data captures wr_data instead of the array value.
- Undefined: no forwarding; old value is returned as above.
- The macro does not alter write, clear, or pulse timing.

Test Plan:
- Reset, then valid=1 with rs=3, rt=4 -> next cycle rd_data1=0, rd_data2=0, rd_valid=1; busy=0, end_instr=0.
- wr_en=1, wr_dst_sel=1, rd=5, wr_data=0xDEADBEEF -> end_instr=1 for one cycle; then a read with rs=5 -> rd_data1=0xDEADBEEF one cycle later.
- wr_dst_sel=2, wr_data=0x00400008 -> reg31 holds it; write to rt=0 with 0x1234 -> read r0 = 0 and end_instr still pulses.
- Same-cycle write r7=0xA5A5A5A5 and read rs=7 -> rd_data1 = previous value (0) without REGFILE_BYPASS_EN, 0xA5A5A5A5 with it.
- Fill r1..r31 with nonzero values, pulse clr_req -> busy high exactly 32 cycles; writes/reads during busy produce no end_instr/rd_valid; all reads afterwards = 0.
- Drop reset low mid-clear (cycle 10) with wr_en pending -> all outputs 0 immediately; after release state is IDLE and a new write/read works normally.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read request and instruction word, write port,
// and the clear request, together with registered read data and status.
interface regfile_mp_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [31:0]       instruction;
  logic              wr_en;
  logic [1:0]        wr_dst_sel;
  logic [DATA_W-1:0] wr_data;
  logic              clr_req;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;
  logic              rd_valid;
  logic              end_instr;
  logic              busy;

  modport master (
    output valid, instruction, wr_en, wr_dst_sel, wr_data, clr_req,
    input  rd_data1, rd_data2, rd_valid, end_instr, busy
  );

  modport slave (
    input  valid, instruction, wr_en, wr_dst_sel, wr_data, clr_req,
    output rd_data1, rd_data2, rd_valid, end_instr, busy
  );
endinterface

// File: rtl/regfile_mp.sv
// MIPS register file: two registered read ports, one rt/rd/link write port,
// optional zero register and a sequenced bulk clear. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int LINK_REG = 31
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rd1_q, rd1_d;
  logic [DATA_W-1:0] rd2_q, rd2_d;
  logic              rd_valid_q, rd_valid_d;
  logic              end_instr_q, end_instr_d;
  logic              busy_q, busy_d;

  logic [ADDR_W-1:0] rs, rt, rd, wr_addr;
  logic              wr_ok, wr_store;
  logic              unused_instr;

  assign rs = bus.instruction[21 +: ADDR_W];
  assign rt = bus.instruction[16 +: ADDR_W];
  assign rd = bus.instruction[11 +: ADDR_W];
  assign unused_instr = ^bus.instruction;

  always_comb begin
    wr_addr = rt;
    case (bus.wr_dst_sel)
      2'd1:    wr_addr = rd;
      2'd2:    wr_addr = LINK_ADDR;
      default: wr_addr = rt;
    endcase
  end

  // A write counts (pulses end_instr) unless reserved or pre-empted by a clear;
  // it only reaches the array when it does not target the hardwired zero register.
  assign wr_ok    = bus.wr_en && (bus.wr_dst_sel != 2'd3) && !bus.clr_req;
  assign wr_store = wr_ok && !((ZERO_REG != 0) && (wr_addr == '0));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    mem_d       = mem_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    rd_valid_d  = 1'b0;
    end_instr_d = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.valid) begin
          rd1_d      = ((ZERO_REG != 0) && (rs == '0)) ? '0 : mem_q[rs];
          rd2_d      = ((ZERO_REG != 0) && (rt == '0)) ? '0 : mem_q[rt];
`ifdef REGFILE_BYPASS_EN
          if (wr_store && (wr_addr == rs)) rd1_d = bus.wr_data;
          if (wr_store && (wr_addr == rt)) rd2_d = bus.wr_data;
`endif
          rd_valid_d = 1'b1;
        end
        if (bus.clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else if (wr_ok) begin
          end_instr_d = 1'b1;
          if (wr_store) mem_d[wr_addr] = bus.wr_data;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      rd_valid_q  <= 1'b0;
      end_instr_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      rd_valid_q  <= rd_valid_d;
      end_instr_q <= end_instr_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.rd_data1  = rd1_q;
  assign bus.rd_data2  = rd2_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.end_instr = end_instr_q;
  assign bus.busy      = busy_q;
endmodule
